// File: rtl/swin_frame_seq.sv
// Frame sequencer for the 3x3 slide-window: feeds one raster frame, appends flush pixels, re-arms the window.
// Optional DRAIN watchdog (ERR output) is built when SWIN_SEQ_TIMEOUT_EN is defined.
module swin_frame_seq #(
  parameter int              P_WIDTH      = 320,
  parameter int              P_HEIGHT     = 240,
  parameter int              P_PIX_CNT_W  = 17,
  parameter int              DW           = 1,
  parameter logic [DW-1:0]   P_FLUSH_VAL  = '0,
  parameter int              P_RST_CYCLES = 2,
  parameter int              P_TIMEOUT    = 1024
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   START,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  input  logic                   S_VALID,
  output logic                   S_READY,
  input  logic [DW-1:0]          S_DATA,
  output logic                   WIN_RSTn,
  output logic                   WIN_DIN_VALID,
  output logic [DW-1:0]          WIN_DIN,
  input  logic                   WIN_VALID,
  input  logic                   WIN_LAST_PIXEL,
  output logic [P_PIX_CNT_W-1:0] OUT_CNT,
  output logic [2:0]             DBG_STATE
);

  localparam int FRAME_PIX = P_WIDTH * P_HEIGHT;
  localparam int FW        = $clog2(P_WIDTH + 1);

  if (P_RST_CYCLES < 1 || P_RST_CYCLES > 15 || P_TIMEOUT < 2 ||
      FRAME_PIX > (2 ** P_PIX_CNT_W) - 1) begin : g_param_check
    $error("swin_frame_seq: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t                 state, state_n;
  logic [P_PIX_CNT_W-1:0] in_cnt, in_cnt_n, out_cnt_n;
  logic [FW-1:0]          flush_cnt, flush_cnt_n;
  logic [3:0]             rst_cnt, rst_cnt_n;
  logic                   busy_n, done_n, win_rstn_n, din_valid_n;
  logic [DW-1:0]          din_n;

  // Upstream handshake: a pixel transfers on a cycle where S_VALID & S_READY;
  // S_READY depends only on the state register, never on S_VALID.
  assign S_READY   = (state == ST_FEED);
  assign DBG_STATE = state;

`ifdef SWIN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT);
  logic [TW-1:0] wd_cnt, wd_n;
  logic          err_n;
`endif

  always_comb begin
    state_n     = state;
    busy_n      = BUSY;
    done_n      = 1'b0;
    win_rstn_n  = WIN_RSTn;
    din_valid_n = 1'b0;
    din_n       = WIN_DIN;
    out_cnt_n   = OUT_CNT;
    in_cnt_n    = in_cnt;
    flush_cnt_n = flush_cnt;
    rst_cnt_n   = rst_cnt;
`ifdef SWIN_SEQ_TIMEOUT_EN
    wd_n        = wd_cnt;
    err_n       = 1'b0;
`endif

    if ((state == ST_FEED || state == ST_FLUSH || state == ST_DRAIN) &&
        WIN_VALID && (OUT_CNT != {P_PIX_CNT_W{1'b1}}))
      out_cnt_n = OUT_CNT + 1'b1;

    case (state)
      ST_IDLE: begin
        win_rstn_n = 1'b1;
        busy_n     = 1'b0;
        if (START) begin
          state_n     = ST_CLR;
          busy_n      = 1'b1;
          win_rstn_n  = 1'b0;
          out_cnt_n   = '0;
          in_cnt_n    = '0;
          flush_cnt_n = '0;
          rst_cnt_n   = '0;
        end
      end
      ST_CLR: begin
        rst_cnt_n = rst_cnt + 1'b1;
        if (rst_cnt == 4'(P_RST_CYCLES - 1)) begin
          state_n    = ST_FEED;
          win_rstn_n = 1'b1;
        end
      end
      ST_FEED: begin
        if (S_VALID) begin
          din_valid_n = 1'b1;
          din_n       = S_DATA;
          in_cnt_n    = in_cnt + 1'b1;
          if (in_cnt == P_PIX_CNT_W'(FRAME_PIX - 1)) begin
            state_n     = ST_FLUSH;
            flush_cnt_n = '0;
          end
        end
      end
      ST_FLUSH: begin
        // P_WIDTH+1 flush pushes, back-to-back with the last frame pixel
        din_valid_n = 1'b1;
        din_n       = P_FLUSH_VAL;
        flush_cnt_n = flush_cnt + 1'b1;
        if (flush_cnt == FW'(P_WIDTH)) begin
          state_n = ST_DRAIN;
`ifdef SWIN_SEQ_TIMEOUT_EN
          wd_n    = '0;
`endif
        end
      end
      ST_DRAIN: begin
        if (WIN_LAST_PIXEL) begin
          state_n = ST_FIN;
          done_n  = 1'b1;
        end
`ifdef SWIN_SEQ_TIMEOUT_EN
        else if (wd_cnt == TW'(P_TIMEOUT - 1)) begin
          state_n = ST_FIN;
          done_n  = 1'b1;
        end else begin
          // ERR is raised so it is visible during the final watchdog cycle
          wd_n  = wd_cnt + 1'b1;
          err_n = (wd_cnt == TW'(P_TIMEOUT - 2));
        end
`endif
      end
      ST_FIN: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state         <= ST_IDLE;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      WIN_RSTn      <= 1'b0;
      WIN_DIN_VALID <= 1'b0;
      WIN_DIN       <= P_FLUSH_VAL;
      OUT_CNT       <= '0;
      in_cnt        <= '0;
      flush_cnt     <= '0;
      rst_cnt       <= '0;
    end else begin
      state         <= state_n;
      BUSY          <= busy_n;
      DONE          <= done_n;
      WIN_RSTn      <= win_rstn_n;
      WIN_DIN_VALID <= din_valid_n;
      WIN_DIN       <= din_n;
      OUT_CNT       <= out_cnt_n;
      in_cnt        <= in_cnt_n;
      flush_cnt     <= flush_cnt_n;
      rst_cnt       <= rst_cnt_n;
    end
  end

`ifdef SWIN_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wd_cnt <= '0;
      ERR    <= 1'b0;
    end else begin
      wd_cnt <= wd_n;
      ERR    <= err_n;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_swin_frame_seq.sv
// Directed bench for swin_frame_seq (4x3 frame) with a small behavioural window and a pixel scoreboard.
module tb_swin_frame_seq;

  localparam int         W  = 4;
  localparam int         H  = 3;
  localparam int         CW = 17;
  localparam logic [7:0] FV = 8'hEE;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          START = 1'b0;
  logic          S_VALID = 1'b0;
  logic [7:0]    S_DATA = 8'h00;
  logic          BUSY, DONE, ERR, S_READY, WIN_RSTn, WIN_DIN_VALID;
  logic [7:0]    WIN_DIN;
  logic          WIN_VALID, WIN_LAST_PIXEL;
  logic [CW-1:0] OUT_CNT;
  logic [2:0]    DBG_STATE;

  swin_frame_seq #(
    .P_WIDTH(W), .P_HEIGHT(H), .P_PIX_CNT_W(CW), .DW(8),
    .P_FLUSH_VAL(FV), .P_RST_CYCLES(2), .P_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .WIN_RSTn(WIN_RSTn), .WIN_DIN_VALID(WIN_DIN_VALID), .WIN_DIN(WIN_DIN),
    .WIN_VALID(WIN_VALID), .WIN_LAST_PIXEL(WIN_LAST_PIXEL),
    .OUT_CNT(OUT_CNT), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // window model: first W+1 pushes fill the line buffer, then one output per push, 2-cycle latency
  int   wpush = 0;
  logic v1 = 1'b0, v2 = 1'b0, l1 = 1'b0, l2 = 1'b0;
  logic force_no_last = 1'b0;
  logic last_inject = 1'b0;
  assign WIN_VALID      = v2;
  assign WIN_LAST_PIXEL = l2 | last_inject;

  always @(posedge CLK) begin
    if (!RSTn || !WIN_RSTn) begin
      wpush <= 0; v1 <= 1'b0; v2 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0;
    end else begin
      if (WIN_DIN_VALID) wpush <= wpush + 1;
      v1 <= WIN_DIN_VALID && (wpush >= W + 1);
      l1 <= WIN_DIN_VALID && (wpush == W * H + W) && !force_no_last;
      v2 <= v1;
      l2 <= l1;
    end
  end

  // scoreboard and counters
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = FV;
  logic       rst_at_edge = 1'b1;
  int         push_n = 0, done_n = 0, err_n = 0, rstlow_n = 0, cur_run = 0, last_run = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) rst_at_edge <= !RSTn;

  always @(negedge CLK) begin : monitor
    logic [7:0] e;
    if (rst_at_edge) exp_q.delete();
    if (WIN_DIN_VALID) begin
      push_n  <= push_n + 1;
      cur_run <= cur_run + 1;
      if (exp_q.size() == 0) begin
        chk("din_extra", 32'(WIN_DIN), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        last_exp <= e;
        chk("din", 32'(WIN_DIN), 32'(e));
      end
    end else begin
      chk("din_hold", 32'(WIN_DIN), 32'(rst_at_edge ? FV : last_exp));
      if (rst_at_edge) last_exp <= FV;
      if (cur_run != 0) begin
        last_run <= cur_run;
        cur_run  <= 0;
      end
    end
    if (DONE)      done_n   <= done_n + 1;
    if (ERR)       err_n    <= err_n + 1;
    if (!WIN_RSTn) rstlow_n <= rstlow_n + 1;
  end

  function automatic logic [7:0] pix(input int fid, input int i);
    return 8'(fid * 16 + i + 1);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},  32'(BUSY), 0);
    chk({tag, "_done"},  32'(DONE), 0);
    chk({tag, "_err"},   32'(ERR), 0);
    chk({tag, "_ready"}, 32'(S_READY), 0);
    chk({tag, "_wrstn"}, 32'(WIN_RSTn), 0);
    chk({tag, "_dv"},    32'(WIN_DIN_VALID), 0);
    chk({tag, "_din"},   32'(WIN_DIN), 32'(FV));
    chk({tag, "_ocnt"},  32'(OUT_CNT), 0);
    chk({tag, "_state"}, 32'(DBG_STATE), 0);
  endtask

  // driver: called at a negedge; pulses START, then streams one frame
  task automatic feed(input int fid, input bit bubbles, input int start_at,
                      input int inject_at, input int abort_at, output int i);
    int  guard = 0;
    bit  mid_done = 0, inj_done = 0;
    i = 0;
    for (int k = 0; k < W * H; k++) exp_q.push_back(pix(fid, k));
    for (int k = 0; k < W + 1; k++) exp_q.push_back(FV);
    while (i < W * H && guard < 200) begin
      if (i == abort_at) break;
      START = (guard == 0);
      if (guard > 0 && i == start_at && !mid_done) begin START = 1'b1; mid_done = 1; end
      last_inject = (i == inject_at && !inj_done);
      if (last_inject) inj_done = 1;
      S_VALID = bubbles ? (guard % 2 == 0) : 1'b1;
      S_DATA  = pix(fid, i);
      if (S_VALID && S_READY) i++;
      guard++;
      @(negedge CLK);
    end
    START       = 1'b0;
    last_inject = 1'b0;
    S_DATA      = 8'h77;
    if (guard >= 200) chk("feed_timeout", 32'(i), 32'(W * H));
  endtask

  task automatic run_frame(input int fid, input bit bubbles, input int start_at,
                           input int inject_at, input bit poke_drain, input int exp_run);
    int d0, p0, r0, i;
    bit ok = 0, poked = 0;
    d0 = done_n; p0 = push_n; r0 = rstlow_n;
    feed(fid, bubbles, start_at, inject_at, -1, i);
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      START = poke_drain && !poked && (DBG_STATE == 3'd4);
      if (START) poked = 1;
      if (DONE) begin ok = 1; break; end
    end
    START = 1'b0;
    chk("done_seen", 32'(ok), 1);
    if (ok) begin
      chk("busy_at_done", 32'(BUSY), 1);
      chk("out_cnt", 32'(OUT_CNT), 32'(W * H));
      chk("push_cnt", 32'(push_n - p0), 32'(W * H + W + 1));
      chk("push_run", 32'(last_run), 32'(exp_run));
      chk("win_rst_low", 32'(rstlow_n - r0), 2);
      chk("sb_empty", 32'(exp_q.size()), 0);
      S_VALID = 1'b0;
      @(negedge CLK);
      chk("busy_after", 32'(BUSY), 0);
      chk("done_pulse", 32'(DONE), 0);
      chk("done_once", 32'(done_n - d0), 1);
      chk("out_hold", 32'(OUT_CNT), 32'(W * H));
      chk("idle", 32'(DBG_STATE), 0);
    end
    S_VALID = 1'b0;
  endtask

  initial begin : main
    int d0, e0, i, dr;
    bit ok;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("rst");
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);

    // nominal, then a back-to-back frame started the cycle after DONE
    run_frame(0, 0, -1, -1, 0, W * H + W + 1);
    run_frame(1, 0, -1, -1, 0, W * H + W + 1);
    // bubbles with a spurious last-pixel flag during FEED
    repeat (2) @(negedge CLK);
    run_frame(2, 1, -1, 3, 0, W + 2);
    // START pulses in FEED and in DRAIN are ignored
    repeat (2) @(negedge CLK);
    run_frame(3, 0, 6, -1, 1, W * H + W + 1);

    // one-cycle reset after pixel 6 aborts the frame
    repeat (2) @(negedge CLK);
    d0 = done_n;
    feed(4, 0, -1, -1, 6, i);
    RSTn = 1'b0; S_VALID = 1'b0;
    @(negedge CLK);
    check_reset("abort");
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);
    chk("abort_no_done", 32'(done_n - d0), 0);
    run_frame(5, 0, -1, -1, 0, W * H + W + 1);

    // window never reports its last pixel
    repeat (2) @(negedge CLK);
    force_no_last = 1'b1;
    d0 = done_n; e0 = err_n;
    feed(6, 0, -1, -1, -1, i);
    S_VALID = 1'b0;
`ifdef SWIN_SEQ_TIMEOUT_EN
    dr = 0; ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (DBG_STATE == 3'd4) dr++;
      if (ERR) begin ok = 1; break; end
    end
    chk("to_err_seen", 32'(ok), 1);
    chk("to_err_cycle", 32'(dr), 8);
    chk("to_err_state", 32'(DBG_STATE), 4);
    chk("to_err_nodone", 32'(DONE), 0);
    @(negedge CLK);
    chk("to_done", 32'(DONE), 1);
    chk("to_err_off", 32'(ERR), 0);
    @(negedge CLK);
    chk("to_busy", 32'(BUSY), 0);
    chk("to_idle", 32'(DBG_STATE), 0);
    chk("to_err_once", 32'(err_n - e0), 1);
`else
    dr = 0;
    repeat (40) @(negedge CLK);
    chk("stuck_drain", 32'(DBG_STATE), 4);
    chk("stuck_busy", 32'(BUSY), 1);
    chk("no_err", 32'(err_n - e0), 0);
    chk("no_done", 32'(done_n - d0), 0);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("stuck_dr_unused", 32'(dr), 0);
`endif
    force_no_last = 1'b0;
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
